// File: rtl/gyro_dir_pkg.sv
// Shared constants for the gyro direction encoder.
//   - UART byte codes for each direction class and the post-calibration marker.
//   - Per-axis direction encoding, where NEG and POS give the sign of the corrected rate.
//   - FSM state type for the encoder top level.
//   - Helpers that map an axis class onto its UART byte.
package gyro_dir_pkg;

  localparam int DATA_W = 16;

  localparam logic [7:0] CODE_TOP    = 8'h00;
  localparam logic [7:0] CODE_BOTTOM = 8'h01;
  localparam logic [7:0] CODE_LEFT   = 8'h02;
  localparam logic [7:0] CODE_RIGHT  = 8'h03;
  localparam logic [7:0] CODE_NONE   = 8'hFF;
  localparam logic [7:0] CODE_CLEAR  = 8'h63;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_NEG  = 2'd1;
  localparam logic [1:0] DIR_POS  = 2'd2;

  typedef enum logic [2:0] {
    ST_CAL,
    ST_SEND_C,
    ST_IDLE,
    ST_LATCH,
    ST_SEND_LR,
    ST_SEND_TB
  } state_t;

  // Y axis: negative rate is LEFT, positive rate is RIGHT.
  function automatic logic [7:0] lr_code(input logic [1:0] dir);
    case (dir)
      DIR_NEG: lr_code = CODE_LEFT;
      DIR_POS: lr_code = CODE_RIGHT;
      default: lr_code = CODE_NONE;
    endcase
  endfunction

  // Z axis: negative rate is TOP, positive rate is BOTTOM.
  function automatic logic [7:0] tb_code(input logic [1:0] dir);
    case (dir)
      DIR_NEG: tb_code = CODE_TOP;
      DIR_POS: tb_code = CODE_BOTTOM;
      default: tb_code = CODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gyro_axis_hyst.sv
// Single-axis classifier. It subtracts the calibrated bias, saturates the result to
// 16 bits, and runs a three-state hysteretic dead zone.
//   clk, rst  clock and asynchronous active-high reset
//   clr       synchronous clear back to NONE; takes priority over en
//   en        update the class from the current sample (one-cycle strobe)
//   sample    signed raw rate
//   bias      signed zero-rate bias
//   dir       current class: DIR_NONE, DIR_NEG or DIR_POS
module gyro_axis_hyst
  import gyro_dir_pkg::*;
#(
  parameter int TH_ON  = 4096,
  parameter int TH_OFF = 2048
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] bias,
  output logic [1:0]               dir
);

  // Clamp a DATA_W+1 bit difference into the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat_diff(input logic signed [DATA_W:0] d);
    if (d[DATA_W] != d[DATA_W-1])
      sat_diff = d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_diff = d[DATA_W-1:0];
  endfunction

  logic signed [DATA_W:0]   diff_p0;
  logic signed [DATA_W-1:0] corr_p0;
  int                       corr_i;
  logic [1:0]               dir_nxt;

  // Stage p0: bias subtraction with one guard bit, then saturation.
  assign diff_p0 = {sample[DATA_W-1], sample} - {bias[DATA_W-1], bias};
  assign corr_p0 = sat_diff(diff_p0);
  assign corr_i  = int'(corr_p0);

  // Strict comparisons: a value exactly on a threshold never changes the class.
  always_comb begin
    dir_nxt = dir;
    case (dir)
      DIR_NEG: begin
        if (corr_i > TH_ON)        dir_nxt = DIR_POS;
        else if (corr_i > -TH_OFF) dir_nxt = DIR_NONE;
      end
      DIR_POS: begin
        if (corr_i < -TH_ON)       dir_nxt = DIR_NEG;
        else if (corr_i < TH_OFF)  dir_nxt = DIR_NONE;
      end
      default: begin
        if (corr_i < -TH_ON)       dir_nxt = DIR_NEG;
        else if (corr_i > TH_ON)   dir_nxt = DIR_POS;
        else                       dir_nxt = DIR_NONE;
      end
    endcase
  end

  // Stage p1: registered class.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      dir <= DIR_NONE;
    else if (clr) dir <= DIR_NONE;
    else if (en)  dir <= dir_nxt;
  end

endmodule

// File: rtl/gyro_dir_encoder.sv
// Gyro direction encoder. It sits between the PmodGYRO reader and the UART transmitter.
// It averages 2^CAL_LOG2 ticks to get a zero-rate bias, then classifies Y and Z on every
// idle tick. Each classification goes out as a two-byte frame (LR, then TB) over a
// ready/send handshake with a post-send guard window.
//   clk, rst    clock and asynchronous active-high reset
//   tick        one-cycle sample strobe
//   data_y/z    signed rates
//   recal       synchronous request to restart calibration
//   tx_ready    UART idle
//   tx_send     one-cycle transmit strobe
//   tx_data     byte being sent
//   calibrated  bias is valid
//   dir_lr      Y class
//   dir_tb      Z class
//   overrun     sticky flag for a tick dropped while busy
module gyro_dir_encoder
  import gyro_dir_pkg::*;
#(
  parameter int CAL_LOG2 = 4,
  parameter int TH_ON    = 4096,
  parameter int TH_OFF   = 2048,
  parameter int GUARD    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic signed [DATA_W-1:0] data_y,
  input  logic signed [DATA_W-1:0] data_z,
  input  logic                     recal,
  input  logic                     tx_ready,
  output logic                     tx_send,
  output logic [7:0]               tx_data,
  output logic                     calibrated,
  output logic [1:0]               dir_lr,
  output logic [1:0]               dir_tb,
  output logic                     overrun
);

  localparam int ACC_W = DATA_W + CAL_LOG2;
  localparam int GRD_W = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc_y, acc_z, acc_y_nxt, acc_z_nxt;
  logic [CAL_LOG2-1:0]      cal_cnt;
  logic signed [DATA_W-1:0] bias_y, bias_z;
  logic [GRD_W-1:0]         guard;
  logic                     can_send, send_fire, cal_done;
  logic [7:0]               send_code;

  assign acc_y_nxt = acc_y + {{CAL_LOG2{data_y[DATA_W-1]}}, data_y};
  assign acc_z_nxt = acc_z + {{CAL_LOG2{data_z[DATA_W-1]}}, data_z};
  // tx_ready is deliberately masked while the guard runs, because the UART has not yet
  // reflected the byte just handed to it.
  assign can_send  = (guard == '0) && tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    send_fire = 1'b0;
    send_code = CODE_NONE;
    cal_done  = 1'b0;
    case (state)
      ST_CAL: begin
        if (tick && (cal_cnt == {CAL_LOG2{1'b1}})) begin
          cal_done  = 1'b1;
          state_nxt = ST_SEND_C;
        end
      end
      ST_SEND_C: begin
        send_code = CODE_CLEAR;
        if (can_send) begin
          send_fire = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE:  if (tick) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_SEND_LR;
      ST_SEND_LR: begin
        send_code = lr_code(dir_lr);
        if (can_send) begin
          send_fire = 1'b1;
          state_nxt = ST_SEND_TB;
        end
      end
      ST_SEND_TB: begin
        send_code = tb_code(dir_tb);
        if (can_send) begin
          send_fire = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_CAL;
    endcase
    // recal abandons whatever is in flight, including a same-cycle tick.
    if (recal) begin
      state_nxt = ST_CAL;
      send_fire = 1'b0;
      cal_done  = 1'b0;
    end
  end

  // Calibration, transmit, guard and overrun registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_y      <= '0;
      acc_z      <= '0;
      cal_cnt    <= '0;
      bias_y     <= '0;
      bias_z     <= '0;
      calibrated <= 1'b0;
      guard      <= '0;
      tx_send    <= 1'b0;
      tx_data    <= 8'h00;
      overrun    <= 1'b0;
    end else if (recal) begin
      // Bias is held so the old value stays in place until the new one exists.
      acc_y      <= '0;
      acc_z      <= '0;
      cal_cnt    <= '0;
      calibrated <= 1'b0;
      guard      <= '0;
      tx_send    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      tx_send <= send_fire;
      if (send_fire) begin
        tx_data <= send_code;
        guard   <= GRD_W'(GUARD);
      end else if (guard != '0) begin
        guard <= guard - GRD_W'(1);
      end
      if ((state == ST_CAL) && tick) begin
        cal_cnt <= cal_cnt + 1'b1;
        if (cal_done) begin
          // The upper slice of the sum is the arithmetic shift by CAL_LOG2.
          bias_y     <= acc_y_nxt[ACC_W-1:CAL_LOG2];
          bias_z     <= acc_z_nxt[ACC_W-1:CAL_LOG2];
          calibrated <= 1'b1;
          acc_y      <= '0;
          acc_z      <= '0;
        end else begin
          acc_y <= acc_y_nxt;
          acc_z <= acc_z_nxt;
        end
      end
      if (tick && (state != ST_CAL) && (state != ST_IDLE))
        overrun <= 1'b1;
    end
  end

  gyro_axis_hyst #(.TH_ON(TH_ON), .TH_OFF(TH_OFF)) u_hyst_y (
    .clk    (clk),
    .rst    (rst),
    .clr    (recal),
    .en     (state == ST_LATCH),
    .sample (data_y),
    .bias   (bias_y),
    .dir    (dir_lr)
  );

  gyro_axis_hyst #(.TH_ON(TH_ON), .TH_OFF(TH_OFF)) u_hyst_z (
    .clk    (clk),
    .rst    (rst),
    .clr    (recal),
    .en     (state == ST_LATCH),
    .sample (data_z),
    .bias   (bias_z),
    .dir    (dir_tb)
  );

endmodule

// File: tb/tb_gyro_dir_encoder.sv
// Self-checking bench for gyro_dir_encoder. It applies directed hysteresis vectors from a
// table, plus hand-written sequences for calibration, saturation, handshake stall and
// overrun, and recal part-way through a frame.
module tb_gyro_dir_encoder;
  import gyro_dir_pkg::*;

  logic               clk = 1'b0;
  logic               rst, tick, recal, tx_ready;
  logic signed [15:0] data_y, data_z;
  logic               tx_send, calibrated, overrun;
  logic [7:0]         tx_data;
  logic [1:0]         dir_lr, dir_tb;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_sent   = 0;
  logic [7:0] rxq[$];

  typedef struct {
    int         y;
    int         z;
    logic [1:0] lr;
    logic [1:0] tb;
    logic [7:0] blr;
    logic [7:0] btb;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  gyro_dir_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .data_y     (data_y),
    .data_z     (data_z),
    .recal      (recal),
    .tx_ready   (tx_ready),
    .tx_send    (tx_send),
    .tx_data    (tx_data),
    .calibrated (calibrated),
    .dir_lr     (dir_lr),
    .dir_tb     (dir_tb),
    .overrun    (overrun)
  );

  always @(posedge clk) begin
    #1;
    if (tx_send === 1'b1) begin
      rxq.push_back(tx_data);
      n_sent++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_pulse(input int y, input int z);
    @(negedge clk);
    data_y = 16'(y);
    data_z = 16'(z);
    tick   = 1'b1;
    @(negedge clk);
    tick   = 1'b0;
  endtask

  task automatic wait_bytes(input string name, input int n, input int budget);
    int k = 0;
    while (rxq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, " bytes arrived"}, 32'(rxq.size() >= n), 32'd1);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    logic [31:0] got;
    got = 32'hDEAD;
    if (rxq.size() > 0) got = 32'(rxq.pop_front());
    check(name, got, 32'(exp));
  endtask

  task automatic calibrate(input string name, input int y, input int z);
    for (int i = 0; i < 15; i++) tick_pulse(y, z);
    check({name, " calibrated after 15"}, 32'(calibrated), 32'd0);
    tick_pulse(y, z);
    check({name, " calibrated after 16"}, 32'(calibrated), 32'd1);
    wait_bytes(name, 1, 20);
    pop_check({name, " clear byte"}, CODE_CLEAR);
    repeat (10) @(negedge clk);
    check({name, " single clear byte"}, 32'(rxq.size()), 32'd0);
  endtask

  task automatic frame(input string name, input int y, input int z, input logic [1:0] elr,
                       input logic [1:0] etb, input logic [7:0] blr, input logic [7:0] btb);
    tick_pulse(y, z);
    wait_bytes(name, 2, 60);
    pop_check({name, " lr byte"}, blr);
    pop_check({name, " tb byte"}, btb);
    check({name, " dir_lr"}, 32'(dir_lr), 32'(elr));
    check({name, " dir_tb"}, 32'(dir_tb), 32'(etb));
    repeat (4) @(negedge clk);
  endtask

  task automatic do_recal(input string name);
    @(negedge clk);
    recal = 1'b1;
    @(negedge clk);
    recal = 1'b0;
    check({name, " calibrated"}, 32'(calibrated), 32'd0);
    check({name, " overrun"}, 32'(overrun), 32'd0);
    check({name, " dir_lr"}, 32'(dir_lr), 32'd0);
    check({name, " dir_tb"}, 32'(dir_tb), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent0;
    // Bias is 0 for these vectors. Rows are applied in order because the class carries over.
    vt[0] = '{-5000,  5000, DIR_NEG,  DIR_POS,  8'h02, 8'h01};
    vt[1] = '{-3000,  3000, DIR_NEG,  DIR_POS,  8'h02, 8'h01};
    vt[2] = '{-2048,  2048, DIR_NEG,  DIR_POS,  8'h02, 8'h01};
    vt[3] = '{-2047,  2047, DIR_NONE, DIR_NONE, 8'hFF, 8'hFF};
    vt[4] = '{ 4096, -4096, DIR_NONE, DIR_NONE, 8'hFF, 8'hFF};
    vt[5] = '{ 4097, -4097, DIR_POS,  DIR_NEG,  8'h03, 8'h00};
    vt[6] = '{-4097,  4097, DIR_NEG,  DIR_POS,  8'h02, 8'h01};
    vt[7] = '{    0,     0, DIR_NONE, DIR_NONE, 8'hFF, 8'hFF};

    rst = 1'b1; tick = 1'b0; recal = 1'b0; tx_ready = 1'b1;
    data_y = '0; data_z = '0;
    repeat (3) @(negedge clk);
    check("reset tx_send", 32'(tx_send), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'h00);
    check("reset calibrated", 32'(calibrated), 32'd0);
    check("reset dir_lr", 32'(dir_lr), 32'd0);
    check("reset dir_tb", 32'(dir_tb), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    // Calibration on 100 / -50. The bias is checked exactly through threshold edges.
    calibrate("cal1", 100, -50);
    check("cal1 overrun", 32'(overrun), 32'd0);
    frame("bias edge", 100 + 4096, -50 - 4096, DIR_NONE, DIR_NONE, 8'hFF, 8'hFF);
    frame("bias over", 100 + 4097, -50 + 4097, DIR_POS, DIR_POS, 8'h03, 8'h01);

    do_recal("recal1");
    calibrate("cal0", 0, 0);
    for (int i = 0; i < 8; i++)
      frame($sformatf("vec%0d", i), vt[i].y, vt[i].z, vt[i].lr, vt[i].tb, vt[i].blr, vt[i].btb);

    // recal after the LR byte: the TB byte is abandoned.
    tick_pulse(-5000, 0);
    wait_bytes("midframe", 1, 30);
    recal = 1'b1;
    @(negedge clk);
    recal = 1'b0;
    check("midframe calibrated", 32'(calibrated), 32'd0);
    check("midframe dir_lr", 32'(dir_lr), 32'd0);
    check("midframe tx_send", 32'(tx_send), 32'd0);
    pop_check("midframe lr byte", 8'h02);
    repeat (20) @(negedge clk);
    check("midframe no tb byte", 32'(rxq.size()), 32'd0);

    // Recalibrate on extreme samples: bias_y = -32768, bias_z = 32767.
    calibrate("calsat", -32768, 32767);
    frame("saturate", 32767, -32768, DIR_POS, DIR_NEG, 8'h03, 8'h00);

    // Stall the UART during SEND_LR and drop a tick into the busy FSM.
    @(negedge clk);
    tx_ready = 1'b0;
    sent0 = n_sent;
    tick_pulse(32767, -32768);
    check("idle tick no overrun", 32'(overrun), 32'd0);
    repeat (50) @(negedge clk);
    tick_pulse(32767, -32768);
    repeat (50) @(negedge clk);
    check("stall no send", 32'(n_sent - sent0), 32'd0);
    check("stall overrun", 32'(overrun), 32'd1);
    tx_ready = 1'b1;
    wait_bytes("stall", 2, 60);
    pop_check("stall lr byte", 8'h03);
    pop_check("stall tb byte", 8'h00);
    check("overrun sticky", 32'(overrun), 32'd1);
    do_recal("recal clears overrun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
